// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: two-entry (main + skid) valid/ready buffer with
// branch resolution from ALU flags and a one-cycle PC redirect pulse.
module ex_mem_stage #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [DATA_W-1:0]  ex_result,
   input  logic               ex_zero,
   input  logic               ex_sign,
   input  logic [DATA_W-1:0]  ex_store_data,
   input  logic [RADDR_W-1:0] ex_rd,
   input  logic               ex_regwrite,
   input  logic               ex_memread,
   input  logic               ex_memwrite,
   input  logic [2:0]         ex_br_op,
   input  logic [DATA_W-1:0]  ex_br_target,
   output logic               mem_valid,
   input  logic               mem_ready,
   output logic [DATA_W-1:0]  mem_alu_result,
   output logic [DATA_W-1:0]  mem_store_data,
   output logic [RADDR_W-1:0] mem_rd,
   output logic               mem_regwrite,
   output logic               mem_memread,
   output logic               mem_memwrite,
   output logic               redirect_valid,
   output logic [DATA_W-1:0]  redirect_pc,
   output logic [1:0]         dbg_state
);

   // Handshake: a beat moves on a rising edge when valid & ready are both high
   // on that edge; valid never waits on ready, and ex_ready/mem_valid are
   // registered so neither depends combinationally on the other side.

   typedef struct packed {
      logic [DATA_W-1:0]  result;
      logic [DATA_W-1:0]  store_data;
      logic [RADDR_W-1:0] rd;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
   } beat_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            state_q;
   beat_t             main_q;
   beat_t             skid_q;
   beat_t             beat_d;
   logic              mem_valid_q;
   logic              ex_ready_q;
   logic              redirect_valid_q;
   logic [DATA_W-1:0] redirect_pc_q;
   logic              accept;
   logic              drain;
   logic              taken_d;

   assign beat_d = {ex_result, ex_store_data, ex_rd, ex_regwrite, ex_memread, ex_memwrite};
   assign accept = ex_valid & ex_ready_q;
   assign drain  = mem_valid_q & mem_ready;

   always_comb begin
      taken_d = 1'b0;
      case (ex_br_op)
         3'b001:  taken_d = ex_zero;
         3'b010:  taken_d = ~ex_zero;
         3'b011:  taken_d = ex_sign;
         3'b100:  taken_d = ~ex_sign;
         3'b101:  taken_d = 1'b1;
         default: taken_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= S_EMPTY;
         main_q           <= '0;
         skid_q           <= '0;
         mem_valid_q      <= 1'b0;
         ex_ready_q       <= 1'b1;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else if (flush) begin
         // Slots are cleared so no stale control reaches MEM after the flush.
         state_q          <= S_EMPTY;
         main_q           <= '0;
         skid_q           <= '0;
         mem_valid_q      <= 1'b0;
         ex_ready_q       <= 1'b1;
         redirect_valid_q <= 1'b0;
      end else begin
         redirect_valid_q <= accept & taken_d;
         if (accept & taken_d) redirect_pc_q <= ex_br_target;
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_q      <= beat_d;
                  mem_valid_q <= 1'b1;
                  state_q     <= S_ONE;
               end
            end
            S_ONE: begin
               if (accept && drain) begin
                  main_q <= beat_d;
               end else if (accept) begin
                  skid_q     <= beat_d;
                  ex_ready_q <= 1'b0;
                  state_q    <= S_TWO;
               end else if (drain) begin
                  main_q      <= '0;
                  mem_valid_q <= 1'b0;
                  state_q     <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (drain) begin
                  main_q     <= skid_q;
                  skid_q     <= '0;
                  ex_ready_q <= 1'b1;
                  state_q    <= S_ONE;
               end
            end
            default: begin
               state_q     <= S_EMPTY;
               main_q      <= '0;
               skid_q      <= '0;
               mem_valid_q <= 1'b0;
               ex_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign ex_ready       = ex_ready_q;
   assign mem_valid      = mem_valid_q;
   assign mem_alu_result = main_q.result;
   assign mem_store_data = main_q.store_data;
   assign mem_rd         = main_q.rd;
   assign mem_regwrite   = main_q.regwrite;
   assign mem_memread    = main_q.memread;
   assign mem_memwrite   = main_q.memwrite;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, flush/reset sequences, and
// random traffic checked against a queue-based model of the stage.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n, flush, ex_valid, ex_zero, ex_sign;
  logic        ex_regwrite, ex_memread, ex_memwrite, mem_ready;
  logic [31:0] ex_result, ex_store_data, ex_br_target;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_br_op;
  logic        ex_ready, mem_valid, mem_regwrite, mem_memread, mem_memwrite, redirect_valid;
  logic [31:0] mem_alu_result, mem_store_data, redirect_pc;
  logic [4:0]  mem_rd;
  logic [1:0]  dbg_state;

  ex_mem_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_zero(ex_zero), .ex_sign(ex_sign), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_br_op(ex_br_op), .ex_br_target(ex_br_target), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a FIFO of up to two beats plus the redirect pulse
  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } beat_t;

  beat_t       mq[$];
  logic        exp_redir = 1'b0;
  logic [31:0] exp_pc = '0;
  bit          live = 1'b0;

  function automatic logic br_taken(input logic [2:0] op, input logic z, input logic s);
    if (op == 3'd1) return z;
    if (op == 3'd2) return !z;
    if (op == 3'd3) return s;
    if (op == 3'd4) return !s;
    if (op == 3'd5) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check();
    beat_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("m_mem_valid", {31'd0, mem_valid}, {31'd0, mq.size() > 0});
    chk("m_ex_ready", {31'd0, ex_ready}, {31'd0, mq.size() < 2});
    chk("m_redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_redir});
    if (exp_redir) chk("m_redirect_pc", redirect_pc, exp_pc);
    chk("m_ctrl", {29'd0, mem_regwrite, mem_memread, mem_memwrite},
        {29'd0, h.regwrite, h.memread, h.memwrite});
    if (mq.size() > 0) begin
      chk("m_result", mem_alu_result, h.result);
      chk("m_store_data", mem_store_data, h.store_data);
      chk("m_rd", {27'd0, mem_rd}, {27'd0, h.rd});
    end
  endtask

  task automatic model_step();
    bit acc, drn;
    if (!rst_n) begin
      mq.delete();
      exp_redir = 1'b0;
      exp_pc    = '0;
      live      = 1'b1;
    end else if (flush) begin
      mq.delete();
      exp_redir = 1'b0;
    end else begin
      acc = ex_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && mem_ready;
      exp_redir = acc && br_taken(ex_br_op, ex_zero, ex_sign);
      if (exp_redir) exp_pc = ex_br_target;
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back({ex_result, ex_store_data, ex_rd, ex_regwrite, ex_memread, ex_memwrite});
    end
  endtask

  // one clock: check pre-edge outputs, advance model, step past the edge
  task automatic cycle();
    @(negedge clk);
    if (live) model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_beat(input logic v, input logic [31:0] res, input logic [4:0] rd,
                            input logic rw, input logic [2:0] op, input logic z, input logic s,
                            input logic [31:0] tgt);
    ex_valid = v; ex_result = res; ex_store_data = res ^ 32'hA5A5_0000; ex_rd = rd;
    ex_regwrite = rw; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_br_op = op; ex_zero = z; ex_sign = s; ex_br_target = tgt;
  endtask

  typedef struct {
    logic        rst_n, flush, valid, mr;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  op;
    logic        z, s;
    logic [31:0] tgt;
    logic        e_mv, e_rdy, e_rv, chk_pc;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic r, input logic f, input logic v, input logic mr,
                         input logic [31:0] res, input logic [4:0] rd, input logic rw,
                         input logic [2:0] op, input logic z, input logic s, input logic [31:0] tgt,
                         input logic e_mv, input logic e_rdy, input logic e_rv, input logic chk_pc,
                         input logic [31:0] e_res, input logic [4:0] e_rd, input logic [31:0] e_pc);
    vec_t t;
    t = '{r, f, v, mr, res, rd, rw, op, z, s, tgt, e_mv, e_rdy, e_rv, chk_pc, e_res, e_rd, e_pc};
    vt.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    drive_beat(1'b0, '0, '0, 1'b0, 3'd0, 1'b0, 1'b0, '0);

    //       rst f  v  mr res           rd rw op  z  s  tgt            mv rdy rv pc  e_res         e_rd e_pc
    add_vec(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 1, 32'h0,        0, 32'h0);
    add_vec(1, 0, 1, 1, 32'h10,       5, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h10,       5, 32'h0);
    add_vec(1, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 32'h0);
    add_vec(1, 0, 1, 0, 32'h11,       1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h11,       1, 32'h0);
    add_vec(1, 0, 1, 0, 32'h22,       2, 1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h11,       1, 32'h0);
    add_vec(1, 0, 1, 0, 32'h33,       3, 1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h11,       1, 32'h0);
    add_vec(1, 0, 1, 1, 32'h33,       3, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h22,       2, 32'h0);
    add_vec(1, 0, 1, 0, 32'h33,       3, 1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h22,       2, 32'h0);
    add_vec(1, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 32'h33,       3, 32'h0);
    add_vec(1, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 32'h0);
    add_vec(1, 0, 1, 1, 32'h77,       8, 0, 1, 1, 0, 32'h0040_0020, 1, 1, 1, 1, 32'h77,       8, 32'h0040_0020);
    add_vec(1, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 32'h0);
    add_vec(1, 0, 1, 1, 32'h44,       4, 1, 3, 0, 0, 32'h0040_0100, 1, 1, 0, 0, 32'h44,       4, 32'h0);
    add_vec(1, 0, 1, 1, 32'h55,       6, 1, 2, 1, 0, 32'h0040_0200, 1, 1, 0, 0, 32'h55,       6, 32'h0);
    add_vec(1, 0, 1, 1, 32'h66,       7, 1, 7, 1, 1, 32'h0040_0300, 1, 1, 0, 0, 32'h66,       7, 32'h0);
    add_vec(1, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 32'h0);

    foreach (vt[i]) begin
      rst_n = vt[i].rst_n; flush = vt[i].flush; mem_ready = vt[i].mr;
      drive_beat(vt[i].valid, vt[i].res, vt[i].rd, vt[i].rw, vt[i].op, vt[i].z, vt[i].s, vt[i].tgt);
      cycle();
      chk($sformatf("tbl%0d_mem_valid", i), {31'd0, mem_valid}, {31'd0, vt[i].e_mv});
      chk($sformatf("tbl%0d_ex_ready", i), {31'd0, ex_ready}, {31'd0, vt[i].e_rdy});
      chk($sformatf("tbl%0d_redirect", i), {31'd0, redirect_valid}, {31'd0, vt[i].e_rv});
      if (vt[i].chk_pc) chk($sformatf("tbl%0d_redirect_pc", i), redirect_pc, vt[i].e_pc);
      if (vt[i].e_mv) begin
        chk($sformatf("tbl%0d_result", i), mem_alu_result, vt[i].e_res);
        chk($sformatf("tbl%0d_rd", i), {27'd0, mem_rd}, {27'd0, vt[i].e_rd});
      end
    end

    // flush while holding two beats, with a jump offered on the same edge
    mem_ready = 1'b0;
    drive_beat(1'b1, 32'h101, 5'd9, 1'b1, 3'd0, 1'b0, 1'b0, '0); cycle();
    drive_beat(1'b1, 32'h102, 5'd10, 1'b1, 3'd0, 1'b0, 1'b0, '0); cycle();
    chk("flush_pre_ready", {31'd0, ex_ready}, 32'd0);
    flush = 1'b1;
    drive_beat(1'b1, 32'h103, 5'd11, 1'b1, 3'd5, 1'b0, 1'b0, 32'h0000_1234); cycle();
    chk("flush_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("flush_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("flush_regwrite", {31'd0, mem_regwrite}, 32'd0);
    flush = 1'b0;
    drive_beat(1'b0, '0, '0, 1'b0, 3'd0, 1'b0, 1'b0, '0); cycle();
    chk("flush_after_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("flush_after_mem_valid", {31'd0, mem_valid}, 32'd0);

    // reset while holding two beats with a redirect pending
    drive_beat(1'b1, 32'h201, 5'd12, 1'b1, 3'd0, 1'b0, 1'b0, '0); cycle();
    drive_beat(1'b1, 32'h202, 5'd13, 1'b1, 3'd5, 1'b0, 1'b0, 32'hDEAD_0000); cycle();
    chk("rst_pre_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("rst_pre_pc", redirect_pc, 32'hDEAD_0000);
    rst_n = 1'b0;
    drive_beat(1'b0, '0, '0, 1'b0, 3'd0, 1'b0, 1'b0, '0); cycle();
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_result", mem_alu_result, 32'd0);
    chk("rst_ctrl", {24'd0, mem_rd, mem_regwrite, mem_memread, mem_memwrite}, 32'd0);
    rst_n = 1'b1; mem_ready = 1'b1; cycle();
    chk("rst_after_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_after_redirect", {31'd0, redirect_valid}, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      mem_ready = ($urandom_range(0, 9) < 6);
      ex_valid  = $urandom_range(0, 1);
      ex_result = $urandom(); ex_store_data = $urandom(); ex_br_target = $urandom();
      ex_rd = 5'($urandom_range(0, 31));
      ex_regwrite = $urandom_range(0, 1); ex_memread = $urandom_range(0, 1);
      ex_memwrite = $urandom_range(0, 1);
      ex_br_op = 3'($urandom_range(0, 7));
      ex_zero = $urandom_range(0, 1); ex_sign = $urandom_range(0, 1);
      cycle();
    end
    rst_n = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
